dispatch_system_register_bank: RTL



---
 rtl/dispatch_system_register_bank.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dispatch_system_register_bank.sv
// Dispatch-stage system register bank (PSR, IDTR, status registers, ...).
// One byte-enabled write port, two combinational read ports and a
// hardware save/restore stack for the entry at P_SAVE_INDEX.
// Optional feature macro: MIST1032ISA_SYSREG_WRITE_BYPASS_EN
//   defined   -> read ports and oSAVE_ENTRY_DATA forward same-cycle updates
//   undefined -> read ports show stored state only (1-cycle write-to-read)
module dispatch_system_register_bank #(
    parameter int P_WIDTH       = 32,
    parameter int P_ENTRY       = 8,
    parameter int P_ENTRY_W     = 3,
    parameter int P_STACK_DEPTH = 4,
    parameter int P_STACK_W     = 2,
    parameter int P_SAVE_INDEX  = 0
) (
    input  logic                   iCLOCK,
    input  logic                   inRESET,
    input  logic                   iRESET_SYNC,
    input  logic                   iWR_VALID,
    input  logic [P_ENTRY_W-1:0]   iWR_INDEX,
    input  logic [P_WIDTH/8-1:0]   iWR_BE,
    input  logic [P_WIDTH-1:0]     iWR_DATA,
    input  logic                   iSAVE_REQ,
    input  logic [P_WIDTH-1:0]     iSAVE_DATA,
    input  logic                   iRESTORE_REQ,
    input  logic                   iERR_CLEAR,
    input  logic [P_ENTRY_W-1:0]   iRD0_INDEX,
    output logic [P_WIDTH-1:0]     oRD0_DATA,
    input  logic [P_ENTRY_W-1:0]   iRD1_INDEX,
    output logic [P_WIDTH-1:0]     oRD1_DATA,
    output logic [P_WIDTH-1:0]     oSAVE_ENTRY_DATA,
    output logic [P_STACK_W:0]     oSTACK_COUNT,
    output logic                   oSTACK_FULL,
    output logic                   oSTACK_EMPTY,
    output logic                   oSTACK_ERROR
);

    localparam int LP_BYTES = P_WIDTH / 8;

    // Registered state
    logic [P_WIDTH-1:0]   entryQ [P_ENTRY];
    logic [P_WIDTH-1:0]   stackQ [P_STACK_DEPTH];
    logic [P_STACK_W:0]   countQ;
    logic                 errorQ;

    // Next-state values (also the forwarding source when bypass is enabled)
    logic [P_WIDTH-1:0]   entryD [P_ENTRY];
    logic [P_WIDTH-1:0]   stackD [P_STACK_DEPTH];
    logic [P_STACK_W:0]   countD;
    logic                 errorD;

    // Values the read ports look at
    logic [P_WIDTH-1:0]   viewArr [P_ENTRY];

    logic                 stackFull;
    logic                 stackEmpty;
    logic                 clearReq;
    logic                 pushReq;
    logic                 popReq;
    logic                 stackErr;
    logic                 wrInRange;
    logic                 wrBlocked;
    logic [P_STACK_W-1:0] pushIdx;
    logic [P_STACK_W-1:0] popIdx;

    // Stack occupancy flags and request decode
    always_comb begin
        stackFull  = (countQ == (P_STACK_W+1)'(P_STACK_DEPTH));
        stackEmpty = (countQ == '0);
        clearReq   = !inRESET || iRESET_SYNC;
        pushReq    = iSAVE_REQ && !iRESTORE_REQ;
        popReq     = iRESTORE_REQ && !iSAVE_REQ;
        stackErr   = (iSAVE_REQ && iRESTORE_REQ) || (pushReq && stackFull) || (popReq && stackEmpty);
        wrInRange  = int'(iWR_INDEX) < P_ENTRY;
        wrBlocked  = (int'(iWR_INDEX) == P_SAVE_INDEX) && (iSAVE_REQ || iRESTORE_REQ);
        pushIdx    = countQ[P_STACK_W-1:0];
        popIdx     = countQ[P_STACK_W-1:0] - 1'b1;
    end

    // Next-state: byte writes first, then save/restore overrides the save entry; clear wins over everything
    always_comb begin
        entryD = entryQ;
        stackD = stackQ;
        countD = countQ;
        errorD = errorQ;

        if (iWR_VALID && wrInRange && !wrBlocked) begin
            for (int b = 0; b < LP_BYTES; b++) begin
                if (iWR_BE[b]) begin
                    entryD[iWR_INDEX][8*b +: 8] = iWR_DATA[8*b +: 8];
                end
            end
        end

        if (pushReq) begin
            entryD[P_SAVE_INDEX] = iSAVE_DATA;
            if (!stackFull) begin
                stackD[pushIdx] = entryQ[P_SAVE_INDEX];
                countD          = countQ + 1'b1;
            end
        end else if (popReq && !stackEmpty) begin
            entryD[P_SAVE_INDEX] = stackQ[popIdx];
            countD               = countQ - 1'b1;
        end

        if (stackErr) begin
            errorD = 1'b1;
        end else if (iERR_CLEAR) begin
            errorD = 1'b0;
        end

        if (clearReq) begin
            for (int i = 0; i < P_ENTRY; i++) begin
                entryD[i] = '0;
            end
            for (int s = 0; s < P_STACK_DEPTH; s++) begin
                stackD[s] = '0;
            end
            countD = '0;
            errorD = 1'b0;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            for (int i = 0; i < P_ENTRY; i++) begin
                entryQ[i] <= '0;
            end
            for (int s = 0; s < P_STACK_DEPTH; s++) begin
                stackQ[s] <= '0;
            end
            countQ <= '0;
            errorQ <= 1'b0;
        end else begin
            entryQ <= entryD;
            stackQ <= stackD;
            countQ <= countD;
            errorQ <= errorD;
        end
    end

    // Select stored or forwarded values for the read side
    always_comb begin
`ifdef MIST1032ISA_SYSREG_WRITE_BYPASS_EN
        viewArr = entryD;
`else
        viewArr = entryQ;
`endif
    end

    // Read ports: out-of-range indices read as zero
    always_comb begin
        oRD0_DATA = '0;
        oRD1_DATA = '0;
        if (int'(iRD0_INDEX) < P_ENTRY) begin
            oRD0_DATA = viewArr[iRD0_INDEX];
        end
        if (int'(iRD1_INDEX) < P_ENTRY) begin
            oRD1_DATA = viewArr[iRD1_INDEX];
        end
        oSAVE_ENTRY_DATA = viewArr[P_SAVE_INDEX];
        oSTACK_COUNT     = countQ;
        oSTACK_FULL      = stackFull;
        oSTACK_EMPTY     = stackEmpty;
        oSTACK_ERROR     = errorQ;
    end

endmodule
